// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   - funct3 encodings for RV32I loads/stores
//   - FSM state type
//   - wait-state counter width
//   - f3_legal(): whether a funct3 is a legal load or store encoding
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Stores have no unsigned variants, so BU/HU are only legal on loads.
    function automatic logic f3_legal(input logic write, input logic [2:0] f3);
        if (write) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bundle between the core load/store path (master) and
// the data-memory responder (slave).
//   req_valid/req_ready   request handshake
//   req_write             1 = store, 0 = load
//   req_funct3            RV32I size/sign encoding
//   req_addr              byte address
//   req_wdata             right-aligned store data
//   resp_valid/resp_ready response handshake
//   resp_rdata            extended load data (0 for stores and errors)
//   resp_err              request rejected
interface dmem_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for a 32-bit word RAM.
//   funct3_i      access size/sign
//   addr_i        byte offset within the word
//   wdata_i       right-aligned store data
//   rword_i       full word read from the RAM
//   byte_mask_o   lanes written by a store
//   wdata_lanes_o store data replicated into every candidate lane
//   rdata_ext_o   selected lane(s) shifted to bit 0 and extended
//   misaligned_o  halfword at odd address or word not on a 4-byte boundary
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  byte_mask_o,
    output logic [31:0] wdata_lanes_o,
    output logic [31:0] rdata_ext_o,
    output logic        misaligned_o
);

    logic [31:0]        shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        shifted       = rword_i >> {addr_i, 3'b000};
        byte_s        = signed'(shifted[7:0]);
        half_s        = signed'(shifted[15:0]);
        byte_mask_o   = 4'b0000;
        wdata_lanes_o = wdata_i;
        misaligned_o  = 1'b0;
        rdata_ext_o   = 32'd0;

        // funct3[1:0] carries the size for both loads and stores.
        case (funct3_i[1:0])
            2'b00: begin
                byte_mask_o   = 4'b0001 << addr_i;
                wdata_lanes_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                byte_mask_o   = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_lanes_o = {2{wdata_i[15:0]}};
                misaligned_o  = addr_i[0];
            end
            2'b10: begin
                byte_mask_o  = 4'b1111;
                misaligned_o = (addr_i != 2'b00);
            end
            default: ;
        endcase

        case (funct3_i)
            F3_B:    rdata_ext_o = 32'(byte_s);
            F3_H:    rdata_ext_o = 32'(half_s);
            F3_W:    rdata_ext_o = rword_i;
            F3_BU:   rdata_ext_o = {24'd0, shifted[7:0]};
            F3_HU:   rdata_ext_o = {16'd0, shifted[15:0]};
            default: rdata_ext_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits
// WAIT_CYCLES, performs the access on an internal word RAM and returns
// the result over a valid/ready response channel.
//   clk    clock
//   reset  synchronous active-high reset (aborts any transaction)
//   bus    dmem_if slave modport (request + response channels)
// Optional: define DMEM_STATS_EN to add stat_loads / stat_stores /
// stat_errs counters, bumped on each response handshake.
// DEPTH_WORDS must be a power of two, at least 2.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic  clk,
    input  logic  reset,
    dmem_if.slave bus
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0] stat_loads,
    output logic [31:0] stat_stores,
    output logic [31:0] stat_errs
`endif
);

    localparam int              AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0]     SPAN     = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              wr_q;
    logic [2:0]        f3_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;

    logic [31:0]       mem_q [DEPTH_WORDS];

    logic              accept;
    logic              fire;
    logic              do_write;
    logic              acc_wr;
    logic [2:0]        acc_f3;
    logic [31:0]       acc_addr;
    logic [31:0]       acc_wdata;
    logic [31:0]       acc_off;
    logic [AW-1:0]     acc_idx;
    logic              acc_err;
    logic [31:0]       rword;
    logic [3:0]        byte_mask;
    logic [31:0]       wdata_lanes;
    logic [31:0]       rdata_ext;
    logic              misaligned;

    assign accept = (state_q == IDLE) && bus.req_valid;

    // With no wait states the access happens on the accept edge itself,
    // so it must use the live request rather than the captured copy.
    assign acc_wr    = (WAIT_CYCLES == 0) ? bus.req_write  : wr_q;
    assign acc_f3    = (WAIT_CYCLES == 0) ? bus.req_funct3 : f3_q;
    assign acc_addr  = (WAIT_CYCLES == 0) ? bus.req_addr   : addr_q;
    assign acc_wdata = (WAIT_CYCLES == 0) ? bus.req_wdata  : wdata_q;
    assign fire      = (WAIT_CYCLES == 0) ? accept : ((state_q == WAIT) && (cnt_q == '0));

    assign acc_off = acc_addr - ADDR_BASE;
    assign acc_idx = acc_off[AW+1:2];
    assign rword   = mem_q[acc_idx];
    assign acc_err = ({1'b0, acc_off} >= SPAN) || misaligned || !f3_legal(acc_wr, acc_f3);

    // Reset on the access edge wins: the store is dropped.
    assign do_write = fire && acc_wr && !acc_err && !reset;

    dmem_lane_align u_align (
        .funct3_i      (acc_f3),
        .addr_i        (acc_addr[1:0]),
        .wdata_i       (acc_wdata),
        .rword_i       (rword),
        .byte_mask_o   (byte_mask),
        .wdata_lanes_o (wdata_lanes),
        .rdata_ext_o   (rdata_ext),
        .misaligned_o  (misaligned)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
                    cnt_d   = CNT_LOAD;
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = RESP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (fire) begin
            err_d   = acc_err;
            rdata_d = (acc_err || acc_wr) ? 32'd0 : rdata_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= bus.req_write;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (do_write && byte_mask[b]) mem_q[acc_idx][b*8 +: 8] <= wdata_lanes[b*8 +: 8];
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

`ifdef DMEM_STATS_EN
    logic [31:0] loads_q, stores_q, errs_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            loads_q  <= 32'd0;
            stores_q <= 32'd0;
            errs_q   <= 32'd0;
        end else if ((state_q == RESP) && bus.resp_ready) begin
            if (err_q)      errs_q   <= errs_q + 32'd1;
            else if (wr_q)  stores_q <= stores_q + 32'd1;
            else            loads_q  <= loads_q + 32'd1;
        end
    end

    assign stat_loads  = loads_q;
    assign stat_stores = stores_q;
    assign stat_errs   = errs_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one DUT with WAIT_CYCLES=1 and one
// with WAIT_CYCLES=3, sharing a stimulus port selected by sel3.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, rst3, sel3;
    logic        t_valid, t_write, t_rready;
    logic [2:0]  t_f3;
    logic [31:0] t_addr, t_wdata;

    dmem_if bus1 ();
    dmem_if bus3 ();

    assign bus1.req_valid  = t_valid && !sel3;
    assign bus3.req_valid  = t_valid && sel3;
    assign bus1.resp_ready = t_rready;
    assign bus3.resp_ready = t_rready;
    assign bus1.req_write  = t_write;
    assign bus3.req_write  = t_write;
    assign bus1.req_funct3 = t_f3;
    assign bus3.req_funct3 = t_f3;
    assign bus1.req_addr   = t_addr;
    assign bus3.req_addr   = t_addr;
    assign bus1.req_wdata  = t_wdata;
    assign bus3.req_wdata  = t_wdata;

    logic        o_req_ready, o_resp_valid, o_err;
    logic [31:0] o_rdata;
    assign o_req_ready  = sel3 ? bus3.req_ready  : bus1.req_ready;
    assign o_resp_valid = sel3 ? bus3.resp_valid : bus1.resp_valid;
    assign o_err        = sel3 ? bus3.resp_err   : bus1.resp_err;
    assign o_rdata      = sel3 ? bus3.resp_rdata : bus1.resp_rdata;

`ifdef DMEM_STATS_EN
    logic [31:0] s1_loads, s1_stores, s1_errs, s3_loads, s3_stores, s3_errs;
`endif

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1), .ADDR_BASE(32'h0)) u_dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (bus1)
`ifdef DMEM_STATS_EN
        , .stat_loads(s1_loads), .stat_stores(s1_stores), .stat_errs(s1_errs)
`endif
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3), .ADDR_BASE(32'h0)) u_dut3 (
        .clk   (clk),
        .reset (rst3),
        .bus   (bus3)
`ifdef DMEM_STATS_EN
        , .stat_loads(s3_loads), .stat_stores(s3_stores), .stat_errs(s3_errs)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Drives one request, completes it with resp_ready=1 and returns what
    // was observed: data, error flag and edges from accept to resp_valid.
    task automatic do_txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output logic er,
                          output int lat);
        int n;
        @(negedge clk);
        t_valid = 1'b1; t_write = w; t_f3 = f3; t_addr = a; t_wdata = d; t_rready = 1'b1;
        n = 0;
        while (!o_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL accept_timeout addr=%h req_ready stayed 0", a);
        end
        @(posedge clk);
        #1 t_valid = 1'b0;
        lat = 0;
        while (!o_resp_valid && lat < 30) begin
            @(posedge clk);
            #1 lat++;
        end
        rd = o_rdata;
        er = o_err;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        sel3 = 1'b0; t_valid = 1'b0; t_write = 1'b0; t_f3 = 3'b0;
        t_addr = 32'h0; t_wdata = 32'h0; t_rready = 1'b1;
        rst1 = 1'b1; rst3 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst1 = 1'b0; rst3 = 1'b0;
        @(negedge clk);
        checks++; if (bus1.req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready1 got %b want 1", bus1.req_ready); end
        checks++; if (bus3.req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready3 got %b want 1", bus3.req_ready); end
        checks++; if (bus1.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b want 0", bus1.resp_valid); end
        checks++; if (bus1.resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", bus1.resp_rdata); end
        checks++; if (bus1.resp_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", bus1.resp_err); end
    endtask

    task automatic test_word_access();
        logic [31:0] rd; logic er; int lat;
        do_txn(1'b1, F3_W, 32'h10, 32'hDEADBEEF, rd, er, lat);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL sw_err got %b want 0", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sw_rdata got %h want 0", rd); end
        checks++; if (lat != 1) begin errors++; $display("FAIL sw_latency got %0d want 1", lat); end
        do_txn(1'b0, F3_W, 32'h10, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got %h want deadbeef", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL lw_err got %b want 0", er); end
        checks++; if (lat != 1) begin errors++; $display("FAIL lw_latency got %0d want 1", lat); end
    endtask

    task automatic test_subword_loads();
        logic [31:0] rd; logic er; int lat;
        do_txn(1'b0, F3_B, 32'h11, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hFFFFFFBE) begin errors++; $display("FAIL lb_11 got %h want ffffffbe", rd); end
        do_txn(1'b0, F3_BU, 32'h11, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h000000BE) begin errors++; $display("FAIL lbu_11 got %h want 000000be", rd); end
        do_txn(1'b0, F3_H, 32'h12, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hFFFFDEAD) begin errors++; $display("FAIL lh_12 got %h want ffffdead", rd); end
        do_txn(1'b0, F3_HU, 32'h12, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h0000DEAD) begin errors++; $display("FAIL lhu_12 got %h want 0000dead", rd); end
        do_txn(1'b0, F3_B, 32'h13, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hFFFFFFDE) begin errors++; $display("FAIL lb_13 got %h want ffffffde", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL lb_13_err got %b want 0", er); end
    endtask

    task automatic test_partial_stores();
        logic [31:0] rd; logic er; int lat;
        do_txn(1'b1, F3_H, 32'h12, 32'h00001234, rd, er, lat);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL sh_err got %b want 0", er); end
        do_txn(1'b0, F3_W, 32'h10, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h1234BEEF) begin errors++; $display("FAIL after_sh got %h want 1234beef", rd); end
        do_txn(1'b1, F3_B, 32'h10, 32'h000000AA, rd, er, lat);
        do_txn(1'b0, F3_W, 32'h10, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h1234BEAA) begin errors++; $display("FAIL after_sb got %h want 1234beaa", rd); end
        do_txn(1'b0, F3_H, 32'h10, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hFFFFBEAA) begin errors++; $display("FAIL lh_10 got %h want ffffbeaa", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        do_txn(1'b1, F3_W, 32'h00, 32'hCAFEF00D, rd, er, lat);
        do_txn(1'b0, F3_W, 32'h02, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL lw_misaligned err=%b rd=%h want err=1 rd=0", er, rd); end
        do_txn(1'b1, F3_H, 32'h13, 32'h0000FFFF, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL sh_odd err=%b rd=%h want err=1 rd=0", er, rd); end
        do_txn(1'b0, F3_W, 32'h1000, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL lw_range err=%b rd=%h want err=1 rd=0", er, rd); end
        do_txn(1'b1, F3_W, 32'h1000, 32'h01020304, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL sw_range err=%b want 1", er); end
        do_txn(1'b0, 3'b011, 32'h00, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL ld_f3_011 err=%b rd=%h want err=1 rd=0", er, rd); end
        do_txn(1'b1, F3_BU, 32'h00, 32'h000000FF, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL st_f3_100 err=%b want 1", er); end
        do_txn(1'b1, F3_W, 32'h01, 32'h11111111, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL sw_misaligned err=%b want 1", er); end
        do_txn(1'b0, F3_W, 32'h00, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hCAFEF00D || er !== 1'b0) begin errors++; $display("FAIL word0_intact rd=%h err=%b want cafef00d/0", rd, er); end
        do_txn(1'b0, F3_W, 32'h10, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h1234BEAA) begin errors++; $display("FAIL word4_intact got %h want 1234beaa", rd); end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        t_valid = 1'b1; t_write = 1'b0; t_f3 = F3_W; t_addr = 32'h10; t_rready = 1'b0;
        @(posedge clk);
        #1;
        n = 0;
        while (!o_resp_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        for (int i = 0; i < 3; i++) begin
            checks++; if (o_resp_valid !== 1'b1 || o_rdata !== 32'h1234BEAA || o_err !== 1'b0)
                begin errors++; $display("FAIL hold_resp cyc%0d valid=%b rd=%h err=%b want 1/1234beaa/0", i, o_resp_valid, o_rdata, o_err); end
            checks++; if (o_req_ready !== 1'b0) begin errors++; $display("FAIL hold_req_ready cyc%0d got %b want 0", i, o_req_ready); end
            @(posedge clk);
            #1;
        end
        t_rready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (o_resp_valid !== 1'b0 || o_req_ready !== 1'b1) begin errors++; $display("FAIL after_hs valid=%b req_ready=%b want 0/1", o_resp_valid, o_req_ready); end
        @(posedge clk);
        #1 t_valid = 1'b0;
        checks++; if (o_req_ready !== 1'b0) begin errors++; $display("FAIL second_accept req_ready=%b want 0", o_req_ready); end
        n = 0;
        while (!o_resp_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        checks++; if (n != 1 || o_rdata !== 32'h1234BEAA) begin errors++; $display("FAIL second_resp lat=%0d rd=%h want 1/1234beaa", n, o_rdata); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er; int lat;
        sel3 = 1'b1;
        do_txn(1'b1, F3_W, 32'h20, 32'h11111111, rd, er, lat);
        checks++; if (lat != 3 || er !== 1'b0) begin errors++; $display("FAIL w3_sw lat=%0d err=%b want 3/0", lat, er); end
        @(negedge clk);
        t_valid = 1'b1; t_write = 1'b1; t_f3 = F3_W; t_addr = 32'h20; t_wdata = 32'h00000055; t_rready = 1'b1;
        @(posedge clk);
        #1 t_valid = 1'b0; rst3 = 1'b1;
        @(posedge clk);
        #1 rst3 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++; if (o_resp_valid !== 1'b0 || o_req_ready !== 1'b1) begin errors++; $display("FAIL abort_idle cyc%0d valid=%b req_ready=%b want 0/1", i, o_resp_valid, o_req_ready); end
            @(posedge clk);
            #1;
        end
        do_txn(1'b0, F3_W, 32'h20, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h11111111) begin errors++; $display("FAIL abort_old_value got %h want 11111111", rd); end
        checks++; if (lat != 3) begin errors++; $display("FAIL w3_lw_latency got %0d want 3", lat); end
        sel3 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_word_access();
        test_subword_loads();
        test_partial_stores();
        test_errors();
        test_backpressure();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout sim time exceeded");
        $fatal(1);
    end

endmodule
